// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_packer width-packing stage.
// Optional packet-boundary support is enabled with PIPE_PACKER_LAST_EN.
package pipe_pkg;

  localparam int unsigned PIPE_L     = 8;
  localparam int unsigned PIPE_N     = 4;
  // Upper bound on the pack factor that keep_mask can describe.
  localparam int unsigned PIPE_MAX_N = 64;

  // Beat-counter width for a pack factor n (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

`ifdef PIPE_PACKER_LAST_EN
  // Thermometer mask with bits 0..cnt set: the lanes holding valid beats.
  function automatic logic [PIPE_MAX_N-1:0] keep_mask(input int unsigned cnt);
    logic [PIPE_MAX_N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PIPE_MAX_N; i++) begin
      m[i] = (i <= cnt);
    end
    return m;
  endfunction
`endif

endpackage

// File: rtl/pipe_packer.sv
// pipe_packer: packs N consecutive L-bit beats into one registered N*L-bit word.
// Build option PIPE_PACKER_LAST_EN adds last_f/last_b/keep_b for short final words.
module pipe_packer
  import pipe_pkg::*;
#(
  parameter int unsigned L = PIPE_L,
  parameter int unsigned N = PIPE_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_f,
  output logic           ready_f,
  input  logic [L-1:0]   data_f,
`ifdef PIPE_PACKER_LAST_EN
  input  logic           last_f,
  output logic           last_b,
  output logic [N-1:0]   keep_b,
`endif
  output logic           valid_b,
  input  logic           ready_b,
  output logic [N*L-1:0] data_b
);

  localparam int unsigned     CW       = cnt_width(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("pipe_packer: N must be at least 2");
  end

`ifdef PIPE_PACKER_LAST_EN
  if (N > PIPE_MAX_N) begin : g_bad_keep
    $error("pipe_packer: N exceeds keep mask width");
  end
`endif

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*L-1:0] acc_q, acc_d;
  logic           valid_q, valid_d;
  logic [N*L-1:0] data_q, data_d;
  logic [31:0]    cnt_ext;
  logic [N*L-1:0] word;
  logic           accept;
  logic           at_last;
  logic           complete;
`ifdef PIPE_PACKER_LAST_EN
  logic           last_q, last_d;
  logic [N-1:0]   keep_q, keep_d;
`endif

  assign cnt_ext = 32'(cnt_q);
  assign accept  = valid_f && ready_f;
  assign at_last = (cnt_q == CNT_LAST);

`ifdef PIPE_PACKER_LAST_EN
  // Any beat may complete a word, so only the output register gates intake.
  assign complete = accept && (at_last || last_f);
  assign ready_f  = !valid_q || ready_b;
`else
  // Only the completing beat needs a free output register.
  assign complete = accept && at_last;
  assign ready_f  = !valid_q || ready_b || !at_last;
`endif

  // Assemble the outgoing word: stored lanes below cnt, live beat at cnt, zero above.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i < cnt_ext) begin
        word[i*L +: L] = acc_q[i*L +: L];
      end else if (i == cnt_ext) begin
        word[i*L +: L] = data_f;
      end
    end
  end

  // Accumulator lane write and beat counter advance.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      acc_d[cnt_ext*L +: L] = data_f;
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end
  end

  // Output register: a completing beat loads a word even while the previous one drains.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef PIPE_PACKER_LAST_EN
    last_d  = last_q;
    keep_d  = keep_q;
`endif
    if (complete) begin
      valid_d = 1'b1;
      data_d  = word;
`ifdef PIPE_PACKER_LAST_EN
      last_d  = last_f;
      keep_d  = N'(keep_mask(cnt_ext));
`endif
    end else if (valid_q && ready_b) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef PIPE_PACKER_LAST_EN
      last_q  <= 1'b0;
      keep_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef PIPE_PACKER_LAST_EN
      last_q  <= last_d;
      keep_q  <= keep_d;
`endif
    end
  end

  assign valid_b = valid_q;
  assign data_b  = data_q;
`ifdef PIPE_PACKER_LAST_EN
  assign last_b  = last_q;
  assign keep_b  = keep_q;
`endif

endmodule
